// File: rtl/aes_byte_rx.sv
// aes_byte_rx
// Chip-side receiver for the AES-128 core. Bytes arrive from a slow external
// driver with a toggle strobe. They are synchronised into clk and assembled
// into 16-byte words. The first word after reset, and any word that starts
// with a rekey request, is presented as a key. Every other word is presented
// as a data block on a valid/ready handshake.
//
// Ports
//   clk        core clock
//   rst        asynchronous reset, active-low
//   in_data    byte from driver (async, stable around each strobe)
//   in_valid   toggle strobe, one level change per byte
//   in_cu      rekey request, sampled at byte 0 of a word
//   in_id      stream tag, sampled at byte 0 of a word
//   key_out    last received key, byte 0 in [127:120]
//   key_valid  one-cycle pulse when key_out updates
//   blk_out    data block, byte 0 in [127:120]
//   blk_id     tag captured with blk_out
//   blk_valid  block available, held until accepted
//   blk_ready  core accepts the block when blk_valid & blk_ready
//   ovf        sticky: block dropped because the previous one was not taken
//   tmo        sticky: partial word discarded on timeout
module aes_byte_rx #(
  parameter int TIMEOUT = 1024,
  parameter int SETTLE  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_cu,
  input  logic         in_id,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [127:0] blk_out,
  output logic         blk_id,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         ovf,
  output logic         tmo
);

  localparam logic [0:0] S_KEY  = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic         v_s1, v_s2, v_d;
  logic         cu_s1, cu_s2;
  logic         id_s1, id_s2;
  logic [7:0]   d_s1, d_s2;
  logic [2:0]   arm;
  logic         strobe;
  logic         capture;

  logic         pend;
  logic [1:0]   scnt;
  logic [3:0]   cnt;
  logic [TW-1:0] tcnt;
  logic [127:0] shift_reg;
  logic         wtype;
  logic         tag;
  logic         done;
  logic [0:0]   state;

  // arm fills with ones after reset. The edge detector is held off until
  // v_d has taken the synchronised in_valid level. A toggle level that is
  // already present at reset release is therefore not seen as a strobe.
  assign strobe  = arm[2] & (v_s2 ^ v_d);
  assign capture = pend & (scnt == 2'(SETTLE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_s1  <= 1'b0;
      v_s2  <= 1'b0;
      v_d   <= 1'b0;
      cu_s1 <= 1'b0;
      cu_s2 <= 1'b0;
      id_s1 <= 1'b0;
      id_s2 <= 1'b0;
      d_s1  <= '0;
      d_s2  <= '0;
      arm   <= '0;
    end else begin
      v_s1  <= in_valid;
      v_s2  <= v_s1;
      v_d   <= v_s2;
      cu_s1 <= in_cu;
      cu_s2 <= cu_s1;
      id_s1 <= in_id;
      id_s2 <= id_s1;
      d_s1  <= in_data;
      d_s2  <= d_s1;
      arm   <= {arm[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      scnt      <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      shift_reg <= '0;
      wtype     <= 1'b0;
      tag       <= 1'b0;
      done      <= 1'b0;
      state     <= S_KEY;
      key_out   <= '0;
      key_valid <= 1'b0;
      blk_out   <= '0;
      blk_id    <= 1'b0;
      blk_valid <= 1'b0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      done      <= 1'b0;

      // Settle window: a strobe seen while a capture is pending is ignored.
      if (capture) begin
        pend <= 1'b0;
      end else if (strobe && !pend) begin
        pend <= 1'b1;
        scnt <= '0;
      end else if (pend) begin
        scnt <= scnt + 2'd1;
      end

      if (capture) begin
        // {~cnt, 3'b111} equals 127 - 8*cnt, the MSB of byte slot cnt.
        shift_reg[{~cnt, 3'b111} -: 8] <= d_s2;
        cnt  <= cnt + 4'd1;
        tcnt <= '0;
        if (cnt == 4'd0) begin
          wtype <= (state == S_KEY) | cu_s2;
          tag   <= id_s2;
        end
        if (cnt == 4'd15) begin
          done <= 1'b1;
        end
      end else if (cnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          cnt  <= '0;
          tcnt <= '0;
          tmo  <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end

      if (blk_valid && blk_ready) begin
        blk_valid <= 1'b0;
      end

      if (done) begin
        if (wtype) begin
          key_out   <= shift_reg;
          key_valid <= 1'b1;
          state     <= S_DATA;
        end else if (!blk_valid || blk_ready) begin
          blk_out   <= shift_reg;
          blk_id    <= tag;
          blk_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_rx.sv
// Self-checking bench for aes_byte_rx. Expected keys and blocks are queued
// when a word is sent, and a negedge monitor pops and compares them.
module tb_aes_byte_rx;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_cu;
  logic         in_id;
  logic [127:0] key_out;
  logic         key_valid;
  logic [127:0] blk_out;
  logic         blk_id;
  logic         blk_valid;
  logic         blk_ready;
  logic         ovf;
  logic         tmo;

  aes_byte_rx #(.TIMEOUT(1024), .SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_cu     (in_cu),
    .in_id     (in_id),
    .key_out   (key_out),
    .key_valid (key_valid),
    .blk_out   (blk_out),
    .blk_id    (blk_id),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .ovf       (ovf),
    .tmo       (tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int key_pulses = 0;
  int exp_keys   = 0;

  logic [127:0] exp_key_q[$];
  logic [127:0] exp_blk_q[$];
  logic         exp_id_q[$];

  typedef struct {
    logic [127:0] word;
    logic         cu;
    logic         id;
    logic         ready;
    logic         is_key;
  } vec_t;

  vec_t vecs[5];

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Data and tags settle 8 clk before the toggle and stay 8+ clk after it.
  task automatic send_byte(input logic [7:0] b, input logic cu, input logic id,
                           input bit meas, output int lat);
    lat = -1;
    @(posedge clk); #1;
    in_data = b;
    in_cu   = cu;
    in_id   = id;
    repeat (8) @(posedge clk);
    #1 in_valid = ~in_valid;
    if (meas) begin
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        if (blk_valid || key_valid) begin
          lat = n;
          break;
        end
      end
      repeat (8) @(posedge clk);
    end else begin
      repeat (8) @(posedge clk);
    end
  endtask

  task automatic send_bytes(input logic [127:0] w, input int nbytes, input logic cu, input logic id);
    logic [127:0] t;
    int l;
    t = w;
    for (int k = 0; k < nbytes; k++) begin
      send_byte(t[127:120], cu, id, 1'b0, l);
      t = t << 8;
    end
  endtask

  task automatic push_key(input logic [127:0] w);
    exp_key_q.push_back(w);
    exp_keys++;
  endtask

  task automatic push_blk(input logic [127:0] w, input logic id);
    exp_blk_q.push_back(w);
    exp_id_q.push_back(id);
  endtask

  task automatic settle_wait();
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [127:0] pout = '0;

  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (key_valid) begin
        key_pulses++;
        if (exp_key_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL key_unexpected: key_valid with key_out=%h, no key queued", key_out);
        end else begin
          check128("key_out", key_out, exp_key_q.pop_front());
        end
      end
      if (blk_valid && (!pv || pr)) begin
        if (exp_blk_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL blk_unexpected: blk_valid with blk_out=%h, no block queued", blk_out);
        end else begin
          check128("blk_out", blk_out, exp_blk_q.pop_front());
          check1("blk_id", blk_id, exp_id_q.pop_front());
        end
      end else if (blk_valid && pv && !pr) begin
        check128("blk_hold", blk_out, pout);
      end
      pv   = blk_valid;
      pr   = blk_ready;
      pout = blk_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [127:0] cur_key;
  logic [127:0] lat_word;
  logic [127:0] t;
  int lat;

  initial begin
    vecs[0] = '{word: {16{8'h00}}, cu: 1'b0, id: 1'b0, ready: 1'b1, is_key: 1'b1};
    vecs[1] = '{word: {16{8'h01}}, cu: 1'b0, id: 1'b0, ready: 1'b1, is_key: 1'b0};
    vecs[2] = '{word: {16{8'h11}}, cu: 1'b1, id: 1'b0, ready: 1'b1, is_key: 1'b1};
    vecs[3] = '{word: 128'h000102030405060708090A0B0C0D0E0F, cu: 1'b0, id: 1'b1, ready: 1'b1, is_key: 1'b0};
    vecs[4] = '{word: 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE, cu: 1'b0, id: 1'b0, ready: 1'b1, is_key: 1'b0};

    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b1;
    in_cu     = 1'b0;
    in_id     = 1'b0;
    blk_ready = 1'b0;
    cur_key   = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check128("rst_key_out", key_out, '0);
    check1("rst_key_valid", key_valid, 1'b0);
    check128("rst_blk_out", blk_out, '0);
    check1("rst_blk_id", blk_id, 1'b0);
    check1("rst_blk_valid", blk_valid, 1'b0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_tmo", tmo, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      blk_ready = vecs[i].ready;
      if (vecs[i].is_key) begin
        push_key(vecs[i].word);
        cur_key = vecs[i].word;
      end else begin
        push_blk(vecs[i].word, vecs[i].id);
      end
      send_bytes(vecs[i].word, 16, vecs[i].cu, vecs[i].id);
      settle_wait();
      check1($sformatf("vec%0d_blk_valid_low", i), blk_valid, 1'b0);
      check128($sformatf("vec%0d_key_out", i), key_out, cur_key);
    end
    check_int("key_pulses_table", key_pulses, exp_keys);

    blk_ready = 1'b0;
    push_blk(128'h000102030405060708090A0B0C0D0E0F, 1'b0);
    send_bytes(128'h000102030405060708090A0B0C0D0E0F, 16, 1'b0, 1'b0);
    settle_wait();
    check1("held_blk_valid", blk_valid, 1'b1);
    check1("ovf_before", ovf, 1'b0);
    send_bytes({16{8'hAA}}, 16, 1'b0, 1'b0);
    settle_wait();
    check1("ovf_after", ovf, 1'b1);
    check128("ovf_blk_out", blk_out, 128'h000102030405060708090A0B0C0D0E0F);
    check1("ovf_blk_valid", blk_valid, 1'b1);
    @(posedge clk); #1;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    check1("accept_blk_valid_fall", blk_valid, 1'b0);

    lat_word = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    push_blk(lat_word, 1'b1);
    send_bytes(lat_word, 15, 1'b0, 1'b1);
    t = lat_word;
    send_byte(t[7:0], 1'b0, 1'b1, 1'b1, lat);
    check_int("latency", lat, 6);
    check1("lat_blk_id", blk_id, 1'b1);

    send_bytes({16{8'h77}}, 5, 1'b0, 1'b0);
    check1("tmo_before", tmo, 1'b0);
    repeat (1030) @(posedge clk);
    #1;
    check1("tmo_after", tmo, 1'b1);
    check1("tmo_no_blk", blk_valid, 1'b0);
    check_int("tmo_no_key", key_pulses, exp_keys);
    push_blk({16{8'h55}}, 1'b0);
    send_bytes({16{8'h55}}, 16, 1'b0, 1'b0);
    repeat (1) @(posedge clk);
    #1;
    check128("tmo_realign_blk_out", blk_out, {16{8'h55}});

    send_bytes({16{8'h99}}, 9, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check128("mid_rst_key_out", key_out, '0);
    check1("mid_rst_key_valid", key_valid, 1'b0);
    check128("mid_rst_blk_out", blk_out, '0);
    check1("mid_rst_blk_id", blk_id, 1'b0);
    check1("mid_rst_blk_valid", blk_valid, 1'b0);
    check1("mid_rst_ovf", ovf, 1'b0);
    check1("mid_rst_tmo", tmo, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    push_key({16{8'h33}});
    send_bytes({16{8'h33}}, 16, 1'b0, 1'b0);
    settle_wait();
    check128("post_rst_key_out", key_out, {16{8'h33}});
    check1("post_rst_blk_valid", blk_valid, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check_int("key_q_empty", exp_key_q.size(), 0);
    check_int("blk_q_empty", exp_blk_q.size(), 0);
    check_int("key_pulses_total", key_pulses, exp_keys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
